// File: rtl/dequantizer_pkg.sv
// Shared constants, FSM encoding and zigzag-to-(row,col) mapping for the
// JPEG dequantizer stage that feeds the IDCT.
package dequantizer_pkg;

    localparam int COEF_BIT_D = 12;
    localparam int QT_BIT_D   = 8;
    localparam int Q_BIT_D    = 32;
    localparam int Q_FRAC_D   = 16;
    localparam int BLOCK_BIT  = 3;
    localparam int NUM_QT_D   = 4;

    // AKIS: streaming coefficients from the entropy decoder.
    // DOLDUR: padding the rest of the block with zeros after an early EOB.
    typedef enum logic {
        AKIS   = 1'b0,
        DOLDUR = 1'b1
    } durum_t;

    // Walks the 15 anti-diagonals of the 8x8 block in JPEG zigzag order and
    // returns {row, col} of the k-th visited position. Odd diagonals run
    // top-right to bottom-left, even diagonals the other way.
    function automatic logic [2*BLOCK_BIT-1:0] zz_rc(input logic [5:0] k);
        logic [2*BLOCK_BIT-1:0] res;
        int n;
        int lo;
        int hi;
        int r;
        res = '0;
        n   = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            for (int i = 0; i < 8; i++) begin
                if (i <= hi - lo) begin
                    r = (s % 2 == 1) ? lo + i : hi - i;
                    if (n == int'(k)) begin
                        res = {r[BLOCK_BIT-1:0], BLOCK_BIT'(s - r)};
                    end
                    n++;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dequantizer_qt_bellek.sv
// Quantization table storage: NUM_QT tables of 64 entries, one write port,
// one combinational read port. Reset loads every entry with 1 so an
// unprogrammed table passes coefficients through unscaled.
module qt_bellek
    import dequantizer_pkg::*;
#(
    parameter int QT_BIT = QT_BIT_D,
    parameter int NUM_QT = NUM_QT_D,
    parameter int TS_BIT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              yaz_i,
    input  logic [TS_BIT-1:0] yaz_sec_i,
    input  logic [5:0]        yaz_adres_i,
    input  logic [QT_BIT-1:0] yaz_veri_i,
    input  logic [TS_BIT-1:0] oku_sec_i,
    input  logic [5:0]        oku_adres_i,
    output logic [QT_BIT-1:0] oku_veri_o
);

    logic [QT_BIT-1:0] r_mem [NUM_QT*64];

    // Single-cycle table write; reset restores identity scaling everywhere.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_QT*64; i++) begin
                r_mem[i] <= QT_BIT'(1);
            end
        end else if (yaz_i) begin
            r_mem[{yaz_sec_i, yaz_adres_i}] <= yaz_veri_i;
        end
    end

    // Same-cycle read of an entry being written sees the old contents.
    assign oku_veri_o = r_mem[{oku_sec_i, oku_adres_i}];

endmodule

// File: rtl/dequantizer.sv
// JPEG dequantizer: scales zigzag-ordered coefficients by the selected
// quantization table, maps them to (row, col), pads early-EOB blocks with
// zeros and emits Q-format values to the IDCT through a 2-stage pipeline.
module dequantizer
    import dequantizer_pkg::*;
#(
    parameter int COEF_BIT  = COEF_BIT_D,
    parameter int QT_BIT    = QT_BIT_D,
    parameter int Q_BIT     = Q_BIT_D,
    parameter int Q_FRAC    = Q_FRAC_D,
    parameter int NUM_QT    = NUM_QT_D,
    localparam int TS_BIT   = (NUM_QT > 1) ? $clog2(NUM_QT) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic signed [COEF_BIT-1:0] hd_veri_i,
    input  logic        [TS_BIT-1:0]   hd_tablo_i,
    input  logic                       hd_gecerli_i,
    input  logic                       hd_blok_son_i,
    output logic                       hd_hazir_o,
    input  logic                       qt_yaz_i,
    input  logic        [TS_BIT-1:0]   qt_sec_i,
    input  logic        [5:0]          qt_adres_i,
    input  logic        [QT_BIT-1:0]   qt_veri_i,
    output logic signed [Q_BIT-1:0]    dq_veri_o,
    output logic        [BLOCK_BIT-1:0] dq_row_o,
    output logic        [BLOCK_BIT-1:0] dq_col_o,
    output logic                       dq_gecerli_o,
    output logic                       dq_blok_son_o,
    input  logic                       dq_hazir_i
);

    localparam int PROD_W = COEF_BIT + QT_BIT + 1;
    localparam int IW     = Q_BIT - Q_FRAC;
    localparam int QMAX   = (1 <<< (IW - 1)) - 1;
    localparam int QMIN   = -(1 <<< (IW - 1));

    // Clamp the integer product into the output integer field, then place it
    // above an all-zero fraction.
    function automatic logic signed [Q_BIT-1:0] sat_q(input logic signed [PROD_W-1:0] p);
        int v;
        v = int'(p);
        if (v > QMAX) begin
            v = QMAX;
        end else if (v < QMIN) begin
            v = QMIN;
        end
        return {v[IW-1:0], {Q_FRAC{1'b0}}};
    endfunction

    durum_t                       r_state;
    durum_t                       w_state_nxt;
    logic [5:0]                   r_k;
    logic [TS_BIT-1:0]            r_tsel;
    logic [TS_BIT-1:0]            w_tsel;
    logic                         w_en;
    logic                         w_accept;
    logic                         w_inject;
    logic                         w_fire;
    logic                         w_last;
    logic [QT_BIT-1:0]            w_qt;
    logic [2*BLOCK_BIT-1:0]       w_rc;

    logic                         r_vld_p1;
    logic                         r_last_p1;
    logic signed [COEF_BIT-1:0]   r_coef_p1;
    logic        [QT_BIT-1:0]     r_qt_p1;
    logic        [BLOCK_BIT-1:0]  r_row_p1;
    logic        [BLOCK_BIT-1:0]  r_col_p1;
    logic signed [PROD_W-1:0]     w_a;
    logic signed [PROD_W-1:0]     w_b;
    logic signed [PROD_W-1:0]     w_prod;

    logic                         r_vld_p2;
    logic                         r_last_p2;
    logic signed [Q_BIT-1:0]      r_veri_p2;
    logic        [BLOCK_BIT-1:0]  r_row_p2;
    logic        [BLOCK_BIT-1:0]  r_col_p2;

    // The whole pipeline freezes only when the output holds data nobody takes.
    assign w_en   = !(r_vld_p2 && !dq_hazir_i);
    assign w_fire = w_accept || w_inject;
    assign w_last = (r_k == 6'd63);
    // The first coefficient reads with the incoming select before it is latched.
    assign w_tsel = (r_k == 6'd0) ? hd_tablo_i : r_tsel;
    assign w_rc   = zz_rc(r_k);

    qt_bellek #(
        .QT_BIT (QT_BIT),
        .NUM_QT (NUM_QT),
        .TS_BIT (TS_BIT)
    ) u_qt_bellek (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .yaz_i       (qt_yaz_i),
        .yaz_sec_i   (qt_sec_i),
        .yaz_adres_i (qt_adres_i),
        .yaz_veri_i  (qt_veri_i),
        .oku_sec_i   (w_tsel),
        .oku_adres_i (r_k),
        .oku_veri_o  (w_qt)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= AKIS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: an early EOB switches to zero padding until k wraps.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AKIS:    if (w_accept && hd_blok_son_i && !w_last) w_state_nxt = DOLDUR;
            DOLDUR:  if (w_en && w_last) w_state_nxt = AKIS;
            default: w_state_nxt = AKIS;
        endcase
    end

    // FSM outputs: upstream is only accepted while streaming and not stalled.
    always_comb begin
        hd_hazir_o = w_en && (r_state == AKIS) && !rst_i;
        w_accept   = hd_hazir_o && hd_gecerli_i;
        w_inject   = w_en && (r_state == DOLDUR);
    end

    // Zigzag index; 6-bit wrap closes the block after entry 63.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_k <= '0;
        end else if (w_fire) begin
            r_k <= r_k + 6'd1;
        end
    end

    // Table select is held for the whole block once its first entry is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tsel <= '0;
        end else if (w_accept && (r_k == 6'd0)) begin
            r_tsel <= hd_tablo_i;
        end
    end

    // ---- stage 1: coefficient, table entry and position ----
    // Stage-1 control.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else if (w_en) begin
            r_vld_p1  <= w_fire;
            r_last_p1 <= w_fire && w_last;
        end
    end

    // Stage-1 data; padded entries carry a zero coefficient.
    always_ff @(posedge clk_i) begin
        if (w_en && w_fire) begin
            r_coef_p1 <= w_inject ? '0 : hd_veri_i;
            r_qt_p1   <= w_qt;
            r_row_p1  <= w_rc[2*BLOCK_BIT-1:BLOCK_BIT];
            r_col_p1  <= w_rc[BLOCK_BIT-1:0];
        end
    end

    assign w_a    = PROD_W'(r_coef_p1);
    assign w_b    = PROD_W'($signed({1'b0, r_qt_p1}));
    assign w_prod = w_a * w_b;

    // ---- stage 2: saturated Q-format product, drives the outputs ----
    // Stage-2 registers; data only moves when a valid entry arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
            r_veri_p2 <= '0;
            r_row_p2  <= '0;
            r_col_p2  <= '0;
        end else if (w_en) begin
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_vld_p1 && r_last_p1;
            if (r_vld_p1) begin
                r_veri_p2 <= sat_q(w_prod);
                r_row_p2  <= r_row_p1;
                r_col_p2  <= r_col_p1;
            end
        end
    end

    assign dq_veri_o     = r_veri_p2;
    assign dq_row_o      = r_row_p2;
    assign dq_col_o      = r_col_p2;
    assign dq_gecerli_o  = r_vld_p2;
    assign dq_blok_son_o = r_last_p2;

endmodule

// File: tb/tb_dequantizer.sv
// Directed bench for the dequantizer with a 24-bit output (8 integer bits).
module tb_dequantizer;

    logic               clk = 1'b0;
    logic               rst_i;
    logic signed [11:0] hd_veri_i;
    logic        [1:0]  hd_tablo_i;
    logic               hd_gecerli_i;
    logic               hd_blok_son_i;
    logic               hd_hazir_o;
    logic               qt_yaz_i;
    logic        [1:0]  qt_sec_i;
    logic        [5:0]  qt_adres_i;
    logic        [7:0]  qt_veri_i;
    logic signed [23:0] dq_veri_o;
    logic        [2:0]  dq_row_o;
    logic        [2:0]  dq_col_o;
    logic               dq_gecerli_o;
    logic               dq_blok_son_o;
    logic               dq_hazir_i = 1'b1;

    dequantizer #(
        .COEF_BIT (12),
        .QT_BIT   (8),
        .Q_BIT    (24),
        .Q_FRAC   (16),
        .NUM_QT   (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .hd_veri_i     (hd_veri_i),
        .hd_tablo_i    (hd_tablo_i),
        .hd_gecerli_i  (hd_gecerli_i),
        .hd_blok_son_i (hd_blok_son_i),
        .hd_hazir_o    (hd_hazir_o),
        .qt_yaz_i      (qt_yaz_i),
        .qt_sec_i      (qt_sec_i),
        .qt_adres_i    (qt_adres_i),
        .qt_veri_i     (qt_veri_i),
        .dq_veri_o     (dq_veri_o),
        .dq_row_o      (dq_row_o),
        .dq_col_o      (dq_col_o),
        .dq_gecerli_o  (dq_gecerli_o),
        .dq_blok_son_o (dq_blok_son_o),
        .dq_hazir_i    (dq_hazir_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] v;
        logic [2:0]  r;
        logic [2:0]  c;
        logic        l;
        int          cyc;
    } ent_t;

    // JPEG zigzag order as natural indices (row*8 + col).
    int zz [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    int                 total = 0;
    int                 bad   = 0;
    int                 cyc   = 0;
    int                 n_unstable = 0;
    bit                 bp_en = 1'b0;
    logic               held_vld = 1'b0;
    logic [31:0]        held = '0;
    ent_t               oq[$];
    int                 acc_q[$];
    logic signed [11:0] stim [64];
    logic [23:0]        exp_v [128];

    function automatic logic [23:0] qv(input int x);
        return 24'(x * 65536);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: always 1 unless random backpressure is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dq_hazir_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Transfers are recorded at the negedge before the edge that takes them.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (hd_gecerli_i && hd_hazir_o) acc_q.push_back(cyc);
            if (dq_gecerli_o && dq_hazir_i)
                oq.push_back('{v: dq_veri_o, r: dq_row_o, c: dq_col_o, l: dq_blok_son_o, cyc: cyc});
            if (held_vld && ({dq_gecerli_o, dq_veri_o, dq_row_o, dq_col_o, dq_blok_son_o} !== held))
                n_unstable <= n_unstable + 1;
        end
        held_vld <= !rst_i && dq_gecerli_o && !dq_hazir_i;
        held     <= {dq_gecerli_o, dq_veri_o, dq_row_o, dq_col_o, dq_blok_son_o};
    end

    task automatic send_block(input int n, input logic [1:0] tab, input bit eob_last);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            int w;
            hd_veri_i     = stim[i];
            hd_tablo_i    = tab;
            hd_blok_son_i = (i == n - 1) && eob_last;
            hd_gecerli_i  = 1'b1;
            w = 0;
            @(negedge clk);
            while (!hd_hazir_o && w < 500) begin
                @(negedge clk);
                w++;
            end
            if (!hd_hazir_o) begin
                total++;
                bad++;
                $display("FAIL send_timeout beat=%0d hazir got=0 want=1", i);
                break;
            end
            @(posedge clk);
            #1;
        end
        hd_gecerli_i  = 1'b0;
        hd_blok_son_i = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int w;
        w = 0;
        while (oq.size() < n && w < 3000) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic qt_write(input logic [1:0] sel, input logic [5:0] adr, input logic [7:0] val);
        @(posedge clk);
        #1;
        qt_yaz_i   = 1'b1;
        qt_sec_i   = sel;
        qt_adres_i = adr;
        qt_veri_i  = val;
        @(posedge clk);
        #1;
        qt_yaz_i   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (dq_gecerli_o !== 1'b0) begin bad++; $display("FAIL rst_gecerli got=%b want=0", dq_gecerli_o); end
        total++; if (dq_veri_o !== 24'h0) begin bad++; $display("FAIL rst_veri got=%h want=0", dq_veri_o); end
        total++; if (dq_blok_son_o !== 1'b0) begin bad++; $display("FAIL rst_blok_son got=%b want=0", dq_blok_son_o); end
        total++; if (hd_hazir_o !== 1'b0) begin bad++; $display("FAIL rst_hazir got=%b want=0", hd_hazir_o); end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        total++; if (hd_hazir_o !== 1'b1) begin bad++; $display("FAIL rst_release_hazir got=%b want=1", hd_hazir_o); end
    endtask

    task automatic test_identity();
        logic [30:0] got;
        logic [30:0] want;
        oq.delete();
        acc_q.delete();
        for (int k = 0; k < 64; k++) stim[k] = 12'(k);
        send_block(64, 2'd0, 1'b1);
        wait_out(64);
        total++; if (oq.size() != 64) begin bad++; $display("FAIL ident_count got=%0d want=64", oq.size()); end
        if (oq.size() > 0 && acc_q.size() > 0) begin
            total++;
            if (oq[0].cyc - acc_q[0] != 2) begin bad++; $display("FAIL ident_latency got=%0d want=2", oq[0].cyc - acc_q[0]); end
        end
        for (int k = 0; k < 64 && k < oq.size(); k++) begin
            got  = {oq[k].v, oq[k].r, oq[k].c, oq[k].l};
            want = {qv(k), 3'(zz[k] / 8), 3'(zz[k] % 8), 1'(k == 63)};
            total++;
            if (got !== want) begin bad++; $display("FAIL ident_k%0d got=%h want=%h", k, got, want); end
        end
    endtask

    task automatic test_table();
        logic [30:0] got;
        logic [30:0] want;
        qt_write(2'd2, 6'd0, 8'd16);
        qt_write(2'd2, 6'd1, 8'd11);
        oq.delete();
        for (int k = 0; k < 64; k++) stim[k] = 12'sd0;
        stim[0] = -12'sd3;
        stim[1] = 12'sd5;
        send_block(64, 2'd2, 1'b1);
        wait_out(64);
        total++; if (oq.size() != 64) begin bad++; $display("FAIL table_count got=%0d want=64", oq.size()); end
        for (int k = 0; k < 64; k++) exp_v[k] = 24'h0;
        exp_v[0] = qv(-48);
        exp_v[1] = qv(55);
        for (int k = 0; k < 64 && k < oq.size(); k++) begin
            got  = {oq[k].v, oq[k].r, oq[k].c, oq[k].l};
            want = {exp_v[k], 3'(zz[k] / 8), 3'(zz[k] % 8), 1'(k == 63)};
            total++;
            if (got !== want) begin bad++; $display("FAIL table_k%0d got=%h want=%h", k, got, want); end
        end
    endtask

    task automatic test_eob();
        logic [30:0] got;
        logic [30:0] want;
        int          low;
        oq.delete();
        for (int k = 0; k < 64; k++) stim[k] = 12'sd7;
        send_block(6, 2'd0, 1'b1);
        low = 0;
        @(negedge clk);
        while (!hd_hazir_o && low < 200) begin
            low++;
            @(negedge clk);
        end
        total++; if (low != 58) begin bad++; $display("FAIL eob_hazir_low got=%0d want=58", low); end
        wait_out(64);
        total++; if (oq.size() != 64) begin bad++; $display("FAIL eob_count got=%0d want=64", oq.size()); end
        for (int k = 0; k < 64 && k < oq.size(); k++) begin
            got  = {oq[k].v, oq[k].r, oq[k].c, oq[k].l};
            want = {(k < 6) ? qv(7) : 24'h0, 3'(zz[k] / 8), 3'(zz[k] % 8), 1'(k == 63)};
            total++;
            if (got !== want) begin bad++; $display("FAIL eob_k%0d got=%h want=%h", k, got, want); end
        end
    endtask

    task automatic test_back_to_back();
        logic [30:0] got;
        logic [30:0] want;
        int          unst0;
        oq.delete();
        unst0 = n_unstable;
        bp_en = 1'b1;
        for (int k = 0; k < 64; k++) stim[k] = 12'(k - 32);
        send_block(64, 2'd0, 1'b1);
        for (int k = 0; k < 64; k++) stim[k] = 12'(3 * k - 100);
        send_block(10, 2'd0, 1'b1);
        wait_out(128);
        bp_en = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (oq.size() != 128) begin bad++; $display("FAIL b2b_count got=%0d want=128", oq.size()); end
        total++; if (n_unstable != unst0) begin bad++; $display("FAIL b2b_stall_stable got=%0d want=%0d", n_unstable, unst0); end
        for (int k = 0; k < 64; k++) exp_v[k] = qv(k - 32);
        for (int k = 0; k < 64; k++) exp_v[64 + k] = (k < 10) ? qv(3 * k - 100) : 24'h0;
        for (int k = 0; k < 128 && k < oq.size(); k++) begin
            got  = {oq[k].v, oq[k].r, oq[k].c, oq[k].l};
            want = {exp_v[k], 3'(zz[k % 64] / 8), 3'(zz[k % 64] % 8), 1'(k % 64 == 63)};
            total++;
            if (got !== want) begin bad++; $display("FAIL b2b_k%0d got=%h want=%h", k, got, want); end
        end
    endtask

    task automatic test_saturation();
        logic [30:0] got;
        logic [30:0] want;
        qt_write(2'd0, 6'd0, 8'd255);
        qt_write(2'd0, 6'd1, 8'd255);
        oq.delete();
        for (int k = 0; k < 64; k++) stim[k] = 12'sd0;
        stim[0] = 12'sd2047;
        stim[1] = -12'sd2048;
        stim[2] = 12'sd127;
        stim[3] = -12'sd128;
        stim[4] = 12'sd128;
        stim[5] = 12'sd3;
        send_block(6, 2'd0, 1'b1);
        wait_out(64);
        total++; if (oq.size() != 64) begin bad++; $display("FAIL sat_count got=%0d want=64", oq.size()); end
        for (int k = 0; k < 64; k++) exp_v[k] = 24'h0;
        exp_v[0] = 24'h7F0000;
        exp_v[1] = 24'h800000;
        exp_v[2] = 24'h7F0000;
        exp_v[3] = 24'h800000;
        exp_v[4] = 24'h7F0000;
        exp_v[5] = 24'h030000;
        for (int k = 0; k < 64 && k < oq.size(); k++) begin
            got  = {oq[k].v, oq[k].r, oq[k].c, oq[k].l};
            want = {exp_v[k], 3'(zz[k] / 8), 3'(zz[k] % 8), 1'(k == 63)};
            total++;
            if (got !== want) begin bad++; $display("FAIL sat_k%0d got=%h want=%h", k, got, want); end
        end
    endtask

    task automatic test_reset_mid();
        logic [30:0] got;
        logic [30:0] want;
        for (int k = 0; k < 64; k++) stim[k] = 12'sd2;
        send_block(30, 2'd0, 1'b0);
        total++; if (dq_gecerli_o !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", dq_gecerli_o); end
        rst_i = 1'b1;
        #1;
        total++; if (dq_gecerli_o !== 1'b0) begin bad++; $display("FAIL mid_rst_gecerli got=%b want=0", dq_gecerli_o); end
        total++; if (dq_veri_o !== 24'h0) begin bad++; $display("FAIL mid_rst_veri got=%h want=0", dq_veri_o); end
        total++; if ({dq_row_o, dq_col_o} !== 6'h0) begin bad++; $display("FAIL mid_rst_rowcol got=%h want=0", {dq_row_o, dq_col_o}); end
        total++; if (hd_hazir_o !== 1'b0) begin bad++; $display("FAIL mid_rst_hazir got=%b want=0", hd_hazir_o); end
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        oq.delete();
        send_block(64, 2'd0, 1'b1);
        wait_out(64);
        total++; if (oq.size() != 64) begin bad++; $display("FAIL mid_count got=%0d want=64", oq.size()); end
        for (int k = 0; k < 64 && k < oq.size(); k++) begin
            got  = {oq[k].v, oq[k].r, oq[k].c, oq[k].l};
            want = {qv(2), 3'(zz[k] / 8), 3'(zz[k] % 8), 1'(k == 63)};
            total++;
            if (got !== want) begin bad++; $display("FAIL mid_k%0d got=%h want=%h", k, got, want); end
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        hd_veri_i     = '0;
        hd_tablo_i    = '0;
        hd_gecerli_i  = 1'b0;
        hd_blok_son_i = 1'b0;
        qt_yaz_i      = 1'b0;
        qt_sec_i      = '0;
        qt_adres_i    = '0;
        qt_veri_i     = '0;
        test_reset();
        test_identity();
        test_table();
        test_eob();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
